// File: rtl/riscv_prog_loader_pkg.sv
// Shared definitions for the program loader.
//   state_t    : loader FSM states (LEN, DATA, CSUM, DONE, ERR)
//   err_code_t : error code reported on err_code
package riscv_prog_loader_pkg;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } err_code_t;

endpackage

// File: rtl/riscv_prog_loader_byte_packer.sv
// Byte-to-word packer. Bytes shift in LSB first; after the fourth byte
// word_valid is high for exactly one cycle with the assembled word.
//   clk, rst   : clock, async active-high reset
//   clear      : sync clear of partial word and byte count
//   in_en      : shift in_byte this cycle
//   in_byte    : byte to pack
//   word_valid : one-cycle strobe, word is complete
//   word       : packed word (holds partial contents between strobes)
module riscv_prog_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      sr         <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_en) begin
        // New byte enters at the top, so after four shifts byte 0 is in [7:0].
        sr         <= {in_byte, sr[31:8]};
        cnt        <= cnt + 2'd1;
        word_valid <= (cnt == 2'd3);
      end
    end
  end

  assign word = sr;

endmodule

// File: rtl/riscv_prog_loader.sv
// Boot loader: receives a length-prefixed, checksummed program image on a
// byte stream and writes it into instruction memory, holding the core in
// reset until the image verifies.
//   clk, rst          : clock, async active-high reset
//   in_data/valid/ready : byte stream handshake
//   reload            : in DONE/ERR, restart loading
//   imem_we/addr/wd   : instruction memory write port
//   core_rst          : core reset, released only in DONE
//   done, err, err_code : load status
module riscv_prog_loader
  import riscv_prog_loader_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic          core_rst,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  state_t      state_q, state_d;
  err_code_t   err_code_q;
  logic [1:0]  byte_cnt;
  logic [31:0] word_cnt;
  logic [31:0] len_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic        byte_done;
  logic        restart;
  logic [31:0] len_full;
  logic        len_bad;
  logic        last_word;

  assign in_ready  = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign accept    = in_valid && in_ready;
  assign byte_done = accept && (byte_cnt == 2'd3);
  assign restart   = reload && ((state_q == DONE) || (state_q == ERR));
  // Length as it will be once the current byte is shifted in.
  assign len_full  = {in_data, len_q[31:8]};
  assign len_bad   = len_full > 32'(MEM_WORDS);
  assign last_word = (word_cnt + 32'd1) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LEN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN:  if (byte_done) begin
              if (len_bad)              state_d = ERR;
              else if (len_full == '0)  state_d = CSUM;
              else                      state_d = DATA;
            end
      DATA: if (byte_done && last_word) state_d = CSUM;
      CSUM: if (accept)                 state_d = (in_data == csum_q) ? DONE : ERR;
      DONE, ERR: if (reload)            state_d = LEN;
      default:                          state_d = LEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      word_cnt   <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      imem_addr  <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        LEN: if (accept) begin
          len_q    <= len_full;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_done && len_bad) begin
            err        <= 1'b1;
            err_code_q <= ERR_LEN;
          end
        end
        DATA: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          csum_q   <= csum_q ^ in_data;
          if (byte_done) begin
            // Address lands together with the packer's strobe.
            imem_addr <= word_cnt[AW-1:0];
            word_cnt  <= word_cnt + 32'd1;
          end
        end
        CSUM: if (accept) begin
          if (in_data == csum_q) begin
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else begin
            err        <= 1'b1;
            err_code_q <= ERR_CSUM;
          end
        end
        DONE, ERR: if (reload) begin
          byte_cnt   <= '0;
          word_cnt   <= '0;
          len_q      <= '0;
          csum_q     <= '0;
          core_rst   <= 1'b1;
          done       <= 1'b0;
          err        <= 1'b0;
          err_code_q <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

  assign err_code = err_code_q;

  riscv_prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .in_en      (accept && (state_q == DATA)),
    .in_byte    (in_data),
    .word_valid (imem_we),
    .word       (imem_wd)
  );

endmodule

// File: tb/tb_riscv_prog_loader.sv
module tb_riscv_prog_loader;

  localparam int MW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          core_rst;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  riscv_prog_loader #(.MEM_WORDS(MW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .core_rst(core_rst),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    img[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected none", imem_addr, imem_wd);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wd} !== e) begin
          n_err++;
          $display("FAIL imem_write actual addr=%0d data=%h expected addr=%0d data=%h",
                   imem_addr, imem_wd, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_imem_we"},  32'(imem_we), 0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
    chk({tag, "_imem_wd"},  imem_wd, 0);
    chk({tag, "_core_rst"}, 32'(core_rst), 1);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_err"},      32'(err), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    chk("reload_core_rst", 32'(core_rst), 1);
    chk("reload_done", 32'(done), 0);
    chk("reload_err", 32'(err), 0);
    chk("reload_err_code", 32'(err_code), 0);
    chk("reload_in_ready", 32'(in_ready), 1);
  endtask

  // Reference: stream = LE length, LE words, XOR of payload bytes.
  // Outcome depends only on n vs. MW and the checksum byte vs. that XOR.
  task automatic load(input logic [31:0] n, input bit force_cs,
                      input logic [7:0] cs_val, input int maxgap);
    logic [7:0] x, cs, b;
    logic [31:0] w;
    x = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], maxgap);
    if (n > 32'(MW)) begin
      idle();
      chk("lenerr_err", 32'(err), 1);
      chk("lenerr_code", 32'(err_code), 1);
      chk("lenerr_core_rst", 32'(core_rst), 1);
      chk("lenerr_in_ready", 32'(in_ready), 0);
      chk("lenerr_done", 32'(done), 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
      idle();
      chk("lenerr_stays", 32'(err_code), 1);
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      w = img[k];
      exp_q.push_back({k[AW-1:0], w});
      for (int i = 0; i < 4; i++) begin
        b = w[8*i +: 8];
        x = x ^ b;
        send_byte(b, maxgap);
      end
    end
    cs = force_cs ? cs_val : x;
    send_byte(cs, maxgap);
    idle();
    if (cs == x) begin
      chk("ok_done", 32'(done), 1);
      chk("ok_core_rst", 32'(core_rst), 0);
      chk("ok_err", 32'(err), 0);
    end else begin
      chk("cs_err", 32'(err), 1);
      chk("cs_err_code", 32'(err_code), 2);
      chk("cs_core_rst", 32'(core_rst), 1);
      chk("cs_done", 32'(done), 0);
    end
    chk("final_in_ready", 32'(in_ready), 0);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int k = 0; k < n; k++) img.push_back($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Directed two-word image, back to back, checksum from the XOR rule.
    img.delete(); img.push_back(32'h00527863); img.push_back(32'h00000013);
    load(32'd2, 1'b0, 8'h00, 0);

    do_reload();
    load(32'd2, 1'b1, 8'h00, 0);           // bad checksum

    do_reload();
    load(32'd65, 1'b0, 8'h00, 0);          // length overflow

    do_reload();
    load(32'd0, 1'b1, 8'h00, 0);           // empty image

    do_reload();
    load(32'd2, 1'b0, 8'h00, 3);           // same image with gaps

    // Reset mid-DATA after 5 bytes; no write may appear.
    do_reload();
    send_byte(8'd2, 0); send_byte(8'd0, 0); send_byte(8'd0, 0); send_byte(8'd0, 0);
    send_byte(8'h63, 0);
    idle();
    rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    fill_img(5);
    load(32'd5, 1'b0, 8'h00, 1);

    // Randomized images from DONE/ERR via reload.
    for (int t = 0; t < 25; t++) begin
      int n;
      logic [31:0] nl;
      bit bad;
      n = int'($urandom_range(12, 0));
      bad = ($urandom_range(3, 0) == 0);
      nl = 32'(n);
      if ($urandom_range(7, 0) == 0) nl = ($urandom_range(1, 0) != 0) ? 32'h0001_0000 : 32'(MW + 1);
      if ($urandom_range(9, 0) == 0) begin nl = 32'(MW); n = MW; end
      fill_img(n);
      do_reload();
      load(nl, bad, 8'($urandom), int'($urandom_range(2, 0)));
    end

    repeat (3) @(negedge clk);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
